add_sub_stream_arb: RTL and testbench



---
 rtl/add_sub_stream_arb.sv | 165 ++++++++++++++++
 tb/tb_add_sub_stream_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_stream_arb.sv
// add_sub_stream_arb
//   Round-robin arbiter that shares one add_sub input stream between NUM_REQ
//   requesters. Its output feeds a two-entry register slice whose ack is registered,
//   so the combinational vld/ack path through this block cannot form a loop.
//   A grant is held for a burst. It is released on a transferred last beat, on the
//   BURST_MAX-th beat, or after IDLE_MAX consecutive cycles with the granted vld low.
//   Each grant costs one IDLE bubble cycle.
//
// Ports
//   ap_clk, ap_rst_n   clock; asynchronous active-low reset
//   req_data           NUM_REQ payloads, requester i at [i*DataWidth +: DataWidth]
//   req_vld, req_last  per-requester valid and end-of-burst
//   req_ack            per-requester accept
//   data_out, vld_out, last_out   stream towards the register slice
//   ack_out            ack from the register slice
//   grant_id           current (or last) granted requester
//   busy               high while a grant is held
//   grant_cnt          release counter; only present when ADD_SUB_ARB_STATS_EN is defined
//
// Optional feature macro: ADD_SUB_ARB_STATS_EN

module add_sub_stream_arb #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned IDLE_MAX  = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ*DataWidth-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [DataWidth-1:0]         data_out,
    output logic                         vld_out,
    output logic                         last_out,
    input  logic                         ack_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef ADD_SUB_ARB_STATS_EN
    ,
    output logic [31:0]                  grant_cnt
`endif
);

    localparam int unsigned IdW = $clog2(NUM_REQ);
    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);
    localparam logic [7:0] IdleLast  = 8'(IDLE_MAX - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic [7:0]     idle_cnt_q, idle_cnt_d;
    logic           rel;

    // Round-robin search: lowest valid index above rr_ptr wins, otherwise the lowest
    // valid index at or below it (the wrap-around part of the search).
    logic           hi_found;
    logic [IdW-1:0] hi_idx, lo_idx, winner;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan so the last assignment is the lowest matching index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                if (IdW'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IdW'(i);
                end else begin
                    lo_idx = IdW'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        vld_out    = 1'b0;
        last_out   = 1'b0;
        data_out   = '0;
        req_ack    = '0;
        busy       = 1'b0;
        rel        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_vld) begin
                    grant_id_d = winner;
                    rr_ptr_d   = winner;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                busy                = 1'b1;
                vld_out             = req_vld[grant_id_q];
                last_out            = req_last[grant_id_q];
                data_out            = req_data[grant_id_q*DataWidth +: DataWidth];
                req_ack[grant_id_q] = ack_out;
                if (vld_out && ack_out) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    idle_cnt_d = '0;
                    rel        = last_out || (beat_cnt_q == BurstLast);
                end else if (!vld_out) begin
                    // A stalled beat (vld high, ack low) is not idle; counters hold.
                    if (idle_cnt_q != 8'hFF) begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                    rel = (idle_cnt_q == IdleLast);
                end
                if (rel) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            rr_ptr_q   <= IdW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign grant_id = grant_id_q;

`ifdef ADD_SUB_ARB_STATS_EN
    logic [31:0] grant_cnt_q;

    // Counts releases; wraps naturally at 32 bits.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            grant_cnt_q <= '0;
        end else if (rel) begin
            grant_cnt_q <= grant_cnt_q + 32'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    // Release statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_add_sub_stream_arb.sv
// Directed bench for add_sub_stream_arb (NUM_REQ=4, BURST_MAX=4, IDLE_MAX=8).
// A small requester model supplies per-requester beat streams whose payloads encode
// requester and beat number, so every expected value is known up front.

module tb_add_sub_stream_arb;

    localparam int DW = 32;
    localparam int NR = 4;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_vld, req_last, req_ack;
    logic [DW-1:0]    data_out;
    logic             vld_out, last_out, ack_out;
    logic [1:0]       grant_id;
    logic             busy;
`ifdef ADD_SUB_ARB_STATS_EN
    logic [31:0]      grant_cnt;
`endif

    add_sub_stream_arb #(
        .DataWidth(DW),
        .NUM_REQ  (NR),
        .BURST_MAX(4),
        .IDLE_MAX (8)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_data(req_data),
        .req_vld (req_vld),
        .req_last(req_last),
        .req_ack (req_ack),
        .data_out(data_out),
        .vld_out (vld_out),
        .last_out(last_out),
        .ack_out (ack_out),
        .grant_id(grant_id),
        .busy    (busy)
`ifdef ADD_SUB_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          beat[NR];
    int          lim[NR];
    logic [NR-1:0] en;
    logic [NR-1:0] pend;
    logic        last2;
    logic        ack_en;

    function automatic logic [31:0] exp_data(int i, int b);
        return 32'hA000_0000 | (32'(i) << 16) | 32'(b);
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_vld[i]            = en[i] && (beat[i] < lim[i]);
            req_data[i*DW +: DW]  = exp_data(i, beat[i]);
            req_last[i]           = last2 && (beat[i] % 2 == 1);
        end
        ack_out = ack_en;
    endtask

    // Apply last cycle's transfers, move to the next negedge, drive, let outputs settle.
    task automatic step();
        for (int i = 0; i < NR; i++) begin
            if (pend[i]) beat[i]++;
        end
        @(negedge ap_clk);
        drive();
        #1;
        pend = req_vld & req_ack;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            beat[i] = 0;
            lim[i]  = 255;
        end
        pend = '0;
    endtask

    task automatic chk_idle(string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".vld"}, 32'(vld_out), 32'd0);
        check_eq({tag, ".ack"}, 32'(req_ack), 32'd0);
        check_eq({tag, ".data"}, data_out, 32'd0);
    endtask

    task automatic chk_beat(string tag, int g, int b, logic lst);
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".vld"}, 32'(vld_out), 32'd1);
        check_eq({tag, ".gid"}, 32'(grant_id), 32'(g));
        check_eq({tag, ".data"}, data_out, exp_data(g, b));
        check_eq({tag, ".last"}, 32'(last_out), 32'(lst));
        check_eq({tag, ".ack"}, 32'(req_ack), ack_en ? (32'd1 << g) : 32'd0);
    endtask

    initial begin
        // Reset, no requests.
        ap_rst_n = 1'b0;
        en       = '0;
        last2    = 1'b0;
        ack_en   = 1'b1;
        clear_model();
        drive();
        #2;
        chk_idle("rst");
        check_eq("rst.gid", 32'(grant_id), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk_idle("idle10");
            check_eq("idle10.gid", 32'(grant_id), 32'd0);
        end

        // All four valid, 2-beat bursts: grants 0,1,2,3,0 each bubble + 2 beats.
        clear_model();
        en    = 4'hF;
        last2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_idle("rr.bub");
            for (int j = 0; j < 2; j++) begin
                step();
                chk_beat("rr", k % 4, 2 * (k / 4) + j, j == 1);
            end
        end

        // Requester 2 alone, 10 beats without last: released after beats 4 and 8.
        clear_model();
        en     = 4'b0100;
        last2  = 1'b0;
        lim[2] = 10;
        for (int r = 0; r < 3; r++) begin
            step();
            chk_idle("bm.bub");
            for (int j = 0; j < ((r == 2) ? 2 : 4); j++) begin
                step();
                chk_beat("bm", 2, 4 * r + j, 1'b0);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("bm.idle.busy", 32'(busy), 32'd1);
            check_eq("bm.idle.vld", 32'(vld_out), 32'd0);
        end
        step();
        chk_idle("bm.rel");

        // Requester 1 granted, then idles 8 cycles while 3 waits.
        clear_model();
        en     = 4'b0010;
        lim[1] = 1;
        step();
        chk_idle("to.bub");
        step();
        chk_beat("to.b0", 1, 0, 1'b0);
        en = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("to.idle.busy", 32'(busy), 32'd1);
            check_eq("to.idle.vld", 32'(vld_out), 32'd0);
            check_eq("to.idle.gid", 32'(grant_id), 32'd1);
            check_eq("to.idle.ack", 32'(req_ack), 32'b0010);
        end
        step();
        chk_idle("to.rel");
        step();
        chk_beat("to.g3", 3, 0, 1'b0);

        // Backpressure: 5 stalled cycles mid-burst, then the burst ends at BURST_MAX.
        ack_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_beat("bp.stall", 3, 1, 1'b0);
        end
        ack_en = 1'b1;
        for (int b = 1; b < 4; b++) begin
            step();
            chk_beat("bp.run", 3, b, 1'b0);
        end
        en = '0;
        step();
        chk_idle("bp.rel");

        // Reset during beat 2 of a grant to requester 2.
        clear_model();
        en    = 4'b1100;
        last2 = 1'b1;
        step();
        chk_idle("mr.bub");
        step();
        chk_beat("mr.b0", 2, 0, 1'b0);
        step();
        chk_beat("mr.b1", 2, 1, 1'b1);
        ap_rst_n = 1'b0;
        pend     = '0;
        #1;
        chk_idle("mr.rst");
        check_eq("mr.rst.gid", 32'(grant_id), 32'd0);
        check_eq("mr.rst.last", 32'(last_out), 32'd0);
        en = 4'b1110;
        drive();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
`ifdef ADD_SUB_ARB_STATS_EN
        check_eq("st.zero", grant_cnt, 32'd0);
`endif
        step();
        chk_beat("mr.g1b0", 1, 0, 1'b0);
        step();
        chk_beat("mr.g1b1", 1, 1, 1'b1);
        step();
        chk_idle("mr.bub2");
`ifdef ADD_SUB_ARB_STATS_EN
        check_eq("st.one", grant_cnt, 32'd1);
`endif
        // Requester 2 resumes the beat it lost to reset.
        step();
        chk_beat("mr.g2", 2, 1, 1'b1);
        step();
        chk_idle("mr.bub3");
`ifdef ADD_SUB_ARB_STATS_EN
        check_eq("st.two", grant_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
